// File: rtl/debug_slave_pkg.sv
// Shared definitions for the system-clock half of the JTAG debug slave:
// IR channel codes, the command FSM state type and synchroniser depth bounds.
package debug_slave_pkg;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACECTRL = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACEMEM  = 2'd3;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } cmd_state_t;

endpackage

// File: rtl/debug_bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
// Depth is clamped into the supported range so an illegal parameter cannot remove the chain.
module debug_bit_sync
   import debug_slave_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : STAGES;

   logic [DEPTH-1:0] chain_r;

   // shift the asynchronous level through the chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain_r <= {DEPTH{1'b0}};
      end else begin
         chain_r <= {chain_r[DEPTH-2:0], d};
      end
   end

   assign q = chain_r[DEPTH-1];

endmodule

// File: rtl/debug_slave_sysclk_cmd.sv
// System-clock side of the debug slave: synchronises the TCK update strobes, captures
// the DR into jdo, decodes take pulses and presents the command through valid/ready.
module debug_slave_sysclk_cmd
   import debug_slave_pkg::*;
#(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IR_W-1:0]      ir_in,
   input  logic [DR_W-1:0]      sr,
   input  logic                 vs_uir,
   input  logic                 vs_udr,
   output logic [DR_W-1:0]      jdo,
   output logic [IR_W-1:0]      cmd_ir,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [2**IR_W-1:0]   take_action,
   output logic [2**IR_W-1:0]   take_no_action,
   output logic                 overrun,
   input  logic                 overrun_clr,
   output logic [CNT_W-1:0]     cmd_count
);

   localparam int NCH = 2**IR_W;
   localparam logic [NCH-1:0]   CH_ONE  = {{(NCH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              uir_sync_s, udr_sync_s;
   logic              uir_prev_r, udr_prev_r;
   logic              uir_evt_r, udr_evt_r;
   logic [IR_W-1:0]   ir_q_r;
   cmd_state_t        state_r, state_next_s;
   logic              load_s, drop_s;
   logic [NCH-1:0]    chan_s;

   logic [DR_W-1:0]   jdo_r;
   logic [IR_W-1:0]   cmd_ir_r;
   logic              cmd_valid_r;
   logic [NCH-1:0]    take_action_r, take_no_action_r;
   logic              overrun_r;
   logic [CNT_W-1:0]  cmd_count_r;

   debug_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
      .clk   (clk),
      .reset (reset),
      .d     (vs_uir),
      .q     (uir_sync_s)
   );

   debug_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk   (clk),
      .reset (reset),
      .d     (vs_udr),
      .q     (udr_sync_s)
   );

   // rising-edge detection on the synchronised strobes, registered into one-cycle events
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uir_prev_r <= 1'b0;
         udr_prev_r <= 1'b0;
         uir_evt_r  <= 1'b0;
         udr_evt_r  <= 1'b0;
         ir_q_r     <= {IR_W{1'b0}};
      end else begin
         uir_prev_r <= uir_sync_s;
         udr_prev_r <= udr_sync_s;
         uir_evt_r  <= uir_sync_s & ~uir_prev_r;
         udr_evt_r  <= udr_sync_s & ~udr_prev_r;
         // a udr event in the same cycle still sees the old ir_q_r through non-blocking update
         if (uir_evt_r) begin
            ir_q_r <= ir_in;
         end else begin
            ir_q_r <= ir_q_r;
         end
      end
   end

   assign chan_s = CH_ONE << ir_q_r;

   // command FSM: load on udr when idle or when the pending command is consumed in the same cycle
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      drop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (udr_evt_r) begin
               state_next_s = PEND;
               load_s       = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         PEND: begin
            if (udr_evt_r && cmd_ready) begin
               state_next_s = PEND;
               load_s       = 1'b1;
            end else if (udr_evt_r) begin
               state_next_s = PEND;
               drop_s       = 1'b1;
            end else if (cmd_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = PEND;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // state, capture registers, take pulses, overrun flag and command counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r          <= IDLE;
         jdo_r            <= {DR_W{1'b0}};
         cmd_ir_r         <= {IR_W{1'b0}};
         cmd_valid_r      <= 1'b0;
         take_action_r    <= {NCH{1'b0}};
         take_no_action_r <= {NCH{1'b0}};
         overrun_r        <= 1'b0;
         cmd_count_r      <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_next_s;
         cmd_valid_r <= (state_next_s == PEND);
         if (load_s) begin
            jdo_r       <= sr;
            cmd_ir_r    <= ir_q_r;
            cmd_count_r <= cmd_count_r + CNT_ONE;
         end else begin
            jdo_r       <= jdo_r;
            cmd_ir_r    <= cmd_ir_r;
            cmd_count_r <= cmd_count_r;
         end
         take_action_r    <= (load_s &&  sr[DR_W-1]) ? chan_s : {NCH{1'b0}};
         take_no_action_r <= (load_s && !sr[DR_W-1]) ? chan_s : {NCH{1'b0}};
         if (drop_s) begin
            overrun_r <= 1'b1;
         end else if (overrun_clr) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign jdo            = jdo_r;
   assign cmd_ir         = cmd_ir_r;
   assign cmd_valid      = cmd_valid_r;
   assign take_action    = take_action_r;
   assign take_no_action = take_no_action_r;
   assign overrun        = overrun_r;
   assign cmd_count      = cmd_count_r;

endmodule

// File: tb/tb_debug_slave_sysclk_cmd.sv
// Self-checking bench for debug_slave_sysclk_cmd: directed scenarios plus a randomized
// sequence checked against a transaction-level model of the command handshake.
module tb_debug_slave_sysclk_cmd;

   localparam int IR_W  = 2;
   localparam int DR_W  = 38;
   localparam int SYNC  = 2;
   localparam int CNT_W = 2;
   localparam int NCH   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [IR_W-1:0]   ir_in;
   logic [DR_W-1:0]   sr;
   logic              vs_uir, vs_udr, cmd_ready, overrun_clr;
   logic [DR_W-1:0]   jdo;
   logic [IR_W-1:0]   cmd_ir;
   logic              cmd_valid, overrun;
   logic [NCH-1:0]    take_action, take_no_action;
   logic [CNT_W-1:0]  cmd_count;

   int errors = 0;
   int checks = 0;

   // transaction-level model
   logic [IR_W-1:0]   m_irq;
   logic              m_pend;
   logic [DR_W-1:0]   m_jdo;
   logic [IR_W-1:0]   m_cmd_ir;
   logic [CNT_W-1:0]  m_count;
   logic              m_ovr;
   logic              e_load;
   logic [NCH-1:0]    e_act, e_nact;

   // observations from the last udr transaction
   int                obs_first, obs_n;
   logic [NCH-1:0]    obs_act, obs_nact;

   debug_slave_sysclk_cmd #(
      .IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
      .vs_uir(vs_uir), .vs_udr(vs_udr), .jdo(jdo), .cmd_ir(cmd_ir),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .take_action(take_action), .take_no_action(take_no_action),
      .overrun(overrun), .overrun_clr(overrun_clr), .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_irq = 2'd0; m_pend = 1'b0; m_jdo = '0; m_cmd_ir = 2'd0;
      m_count = 2'd0; m_ovr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_uir(input logic [IR_W-1:0] ir);
      @(negedge clk);
      ir_in = ir; vs_uir = 1'b1;
      repeat (2) @(negedge clk);
      vs_uir = 1'b0;
      repeat (5) @(negedge clk);
      m_irq = ir;
   endtask

   // model: what a udr strobe should do given the current pending state
   task automatic model_udr(input logic [DR_W-1:0] data, input logic ready_at_evt);
      logic [NCH-1:0] ch;
      ch = 4'b0001 << m_irq;
      e_load = !m_pend || ready_at_evt;
      e_act  = 4'b0000;
      e_nact = 4'b0000;
      if (e_load) begin
         m_jdo = data; m_cmd_ir = m_irq; m_count = m_count + 2'd1; m_pend = 1'b1;
         if (data[DR_W-1]) e_act = ch; else e_nact = ch;
      end else begin
         m_ovr = 1'b1;
      end
   endtask

   task automatic do_udr(input logic [DR_W-1:0] data, input logic ready_at_evt,
                         input logic with_uir, input logic [IR_W-1:0] ir);
      @(negedge clk);
      sr = data; vs_udr = 1'b1;
      if (with_uir) begin
         ir_in = ir; vs_uir = 1'b1;
      end
      obs_first = 0; obs_n = 0; obs_act = 4'b0000; obs_nact = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 2) begin
            vs_udr = 1'b0; vs_uir = 1'b0;
         end
         if ((take_action | take_no_action) != 4'b0000) begin
            obs_n++;
            if (obs_first == 0) obs_first = c;
            obs_act  = obs_act | take_action;
            obs_nact = obs_nact | take_no_action;
         end
         if (c == 3) cmd_ready = ready_at_evt;
         if (c == 4) cmd_ready = 1'b0;
      end
      if (with_uir) m_irq = ir;
   endtask

   task automatic do_accept();
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (jdo !== 38'd0 || cmd_ir !== 2'd0 || cmd_valid !== 1'b0 || take_action !== 4'd0 ||
          take_no_action !== 4'd0 || overrun !== 1'b0 || cmd_count !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: jdo=%h ir=%0d v=%b ta=%b tn=%b ov=%b cnt=%0d required all 0",
                  jdo, cmd_ir, cmd_valid, take_action, take_no_action, overrun, cmd_count);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_action();
      do_uir(2'd2);
      model_udr(38'h20_0000_00AB, 1'b0);
      do_udr(38'h20_0000_00AB, 1'b0, 1'b0, 2'd0);
      checks++;
      if (obs_first !== 4 || obs_n !== 1) begin
         errors++; $display("FAIL action_timing: first=%0d n=%0d required 4 1", obs_first, obs_n);
      end
      checks++;
      if (obs_act !== 4'b0100 || obs_nact !== 4'b0000) begin
         errors++; $display("FAIL action_bits: act=%b nact=%b required 0100 0000", obs_act, obs_nact);
      end
      checks++;
      if (jdo !== 38'h20_0000_00AB || cmd_valid !== 1'b1 || cmd_count !== 2'd1 || cmd_ir !== 2'd2) begin
         errors++;
         $display("FAIL action_cmd: jdo=%h v=%b cnt=%0d ir=%0d required 20000000ab 1 1 2",
                  jdo, cmd_valid, cmd_count, cmd_ir);
      end
      do_accept();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++; $display("FAIL accept_clears_valid: got %b required 0", cmd_valid);
      end
   endtask

   task automatic test_no_action();
      logic [DR_W-1:0] d;
      d = {1'b0, 37'h0_1234_5678};
      do_uir(2'd1);
      model_udr(d, 1'b0);
      do_udr(d, 1'b0, 1'b0, 2'd0);
      checks++;
      if (obs_n !== 1 || obs_nact !== 4'b0010 || obs_act !== 4'b0000) begin
         errors++;
         $display("FAIL no_action_bits: n=%0d act=%b nact=%b required 1 0000 0010", obs_n, obs_act, obs_nact);
      end
      checks++;
      if (jdo !== d || cmd_count !== m_count) begin
         errors++; $display("FAIL no_action_cmd: jdo=%h cnt=%0d required %h %0d", jdo, cmd_count, d, m_count);
      end
      do_accept();
   endtask

   task automatic test_overrun();
      logic [DR_W-1:0] d1, d2;
      d1 = 38'h25_5555_0001;
      d2 = 38'h0A_AAAA_0002;
      model_udr(d1, 1'b0);
      do_udr(d1, 1'b0, 1'b0, 2'd0);
      model_udr(d2, 1'b0);
      do_udr(d2, 1'b0, 1'b0, 2'd0);
      checks++;
      if (overrun !== 1'b1 || obs_n !== 0) begin
         errors++; $display("FAIL overrun_set: ov=%b pulses=%0d required 1 0", overrun, obs_n);
      end
      checks++;
      if (jdo !== d1 || cmd_count !== m_count || cmd_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_keep: jdo=%h cnt=%0d v=%b required %h %0d 1", jdo, cmd_count, cmd_valid, d1, m_count);
      end
      do_clear();
      checks++;
      if (overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_clear: got %b required 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [DR_W-1:0] d;
      d = 38'h3F_0F0F_00CC;
      model_udr(d, 1'b1);
      do_udr(d, 1'b1, 1'b0, 2'd0);
      checks++;
      if (jdo !== d || cmd_valid !== 1'b1 || overrun !== 1'b0 || cmd_count !== m_count) begin
         errors++;
         $display("FAIL back_to_back: jdo=%h v=%b ov=%b cnt=%0d required %h 1 0 %0d",
                  jdo, cmd_valid, overrun, cmd_count, d, m_count);
      end
      checks++;
      if (obs_n !== 1 || obs_act !== e_act) begin
         errors++; $display("FAIL back_to_back_pulse: n=%0d act=%b required 1 %b", obs_n, obs_act, e_act);
      end
      do_accept();
   endtask

   task automatic test_simultaneous();
      do_uir(2'd0);
      model_udr(38'h20_0000_0001, 1'b0);
      do_udr(38'h20_0000_0001, 1'b0, 1'b1, 2'd3);
      checks++;
      if (obs_act !== 4'b0001 || obs_n !== 1) begin
         errors++; $display("FAIL simul_old_ir: act=%b n=%0d required 0001 1", obs_act, obs_n);
      end
      do_accept();
      model_udr(38'h20_0000_0002, 1'b0);
      do_udr(38'h20_0000_0002, 1'b0, 1'b0, 2'd0);
      checks++;
      if (obs_act !== 4'b1000 || cmd_ir !== 2'd3) begin
         errors++; $display("FAIL simul_new_ir: act=%b ir=%0d required 1000 3", obs_act, cmd_ir);
      end
      do_accept();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         model_udr(38'h00_0000_0010 + 38'(i), 1'b0);
         do_udr(38'h00_0000_0010 + 38'(i), 1'b0, 1'b0, 2'd0);
         do_accept();
      end
      checks++;
      if (cmd_count !== 2'd1) begin
         errors++; $display("FAIL count_wrap: got %0d required 1", cmd_count);
      end
   endtask

   task automatic test_reset_pend();
      do_udr(38'h3A_BCDE_F012, 1'b0, 1'b0, 2'd0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (jdo !== 38'd0 || cmd_valid !== 1'b0 || cmd_count !== 2'd0 || overrun !== 1'b0 ||
          take_action !== 4'd0 || take_no_action !== 4'd0 || cmd_ir !== 2'd0) begin
         errors++;
         $display("FAIL reset_async: jdo=%h v=%b cnt=%0d ov=%b required all 0", jdo, cmd_valid, cmd_count, overrun);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic [63:0]     rnd;
      logic [DR_W-1:0] d;
      int              mode;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) do_uir(2'($urandom_range(0, 3)));
         mode = $urandom_range(0, 2);
         if (mode == 0 && m_pend) do_accept();
         if (m_ovr && $urandom_range(0, 1) == 1) do_clear();
         rnd = {$urandom(), $urandom()};
         d = rnd[DR_W-1:0];
         model_udr(d, mode == 2);
         do_udr(d, mode == 2, 1'b0, 2'd0);
         checks++;
         if (obs_act !== e_act || obs_nact !== e_nact || obs_n !== (e_load ? 1 : 0) ||
             (e_load && obs_first !== 4)) begin
            errors++;
            $display("FAIL rand_pulse[%0d]: act=%b nact=%b n=%0d first=%0d required %b %b %0d 4",
                     i, obs_act, obs_nact, obs_n, obs_first, e_act, e_nact, e_load ? 1 : 0);
         end
         checks++;
         if (jdo !== m_jdo || cmd_ir !== m_cmd_ir || cmd_valid !== m_pend ||
             overrun !== m_ovr || cmd_count !== m_count) begin
            errors++;
            $display("FAIL rand_state[%0d]: jdo=%h ir=%0d v=%b ov=%b cnt=%0d required %h %0d %b %b %0d",
                     i, jdo, cmd_ir, cmd_valid, overrun, cmd_count, m_jdo, m_cmd_ir, m_pend, m_ovr, m_count);
         end
      end
   endtask

   initial begin
      reset = 1'b1; ir_in = 2'd0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
      cmd_ready = 1'b0; overrun_clr = 1'b0;
      model_reset();
      test_reset();
      test_action();
      test_no_action();
      test_overrun();
      test_back_to_back();
      test_simultaneous();
      test_wrap();
      test_reset_pend();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
